// File: rtl/pll_supv_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_supv_pkg;

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_WAIT = 3'd1,
        ST_STAB = 3'd2,
        ST_RUN  = 3'd3,
        ST_FAIL = 3'd4
    } supv_state_e;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pll_supv_sync2.sv
// Two-flop synchronizer with asynchronous reset to 0, for raw status inputs.
module pll_supv_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up sequencer and lock supervisor running in the refclk domain.
// Define PLL_SUPV_LOSS_COUNT_EN to add the saturating loss_count output.
module pll_lock_supervisor
    import pll_supv_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned LOSS_FILTER   = 4,
    parameter int unsigned MAX_RETRIES   = 7
) (
    input  logic                                  refclk,
    input  logic                                  rst,
    input  logic                                  pll_locked,
    input  logic                                  restart,
    output logic                                  pll_rst,
    output logic                                  ready,
    output logic                                  fail,
    output logic [cnt_width(MAX_RETRIES)-1:0]     retries,
    output logic [2:0]                            state
`ifdef PLL_SUPV_LOSS_COUNT_EN
    ,
    output logic [7:0]                            loss_count
`endif
);

    localparam int unsigned CW = cnt_width(max4(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES, LOSS_FILTER));
    localparam int unsigned RW = cnt_width(MAX_RETRIES);

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] LOSS_LAST = CW'(LOSS_FILTER - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    logic          lk_s;
    supv_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retries_q, retries_d;
    logic          pll_rst_q, ready_q, fail_q;
    logic          loss_inc;

    pll_supv_sync2 u_lock_sync (
        .clk     (refclk),
        .rst     (rst),
        .async_i (pll_locked),
        .sync_o  (lk_s)
    );

    // restart is evaluated first so it overrides every state's own transition.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
        loss_inc  = 1'b0;
        if (restart) begin
            state_d   = ST_RST;
            cnt_d     = '0;
            retries_d = '0;
        end else begin
            case (state_q)
                ST_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (lk_s) begin
                        state_d = ST_STAB;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        cnt_d = '0;
                        if (retries_q == RETRY_MAX) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d   = ST_RST;
                            retries_d = retries_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_STAB: begin
                    // A dropout here is treated as a glitch, not a retry.
                    if (!lk_s) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == STAB_LAST) begin
                        state_d   = ST_RUN;
                        cnt_d     = '0;
                        retries_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (lk_s) begin
                        cnt_d = '0;
                    end else if (cnt_q == LOSS_LAST) begin
                        state_d  = ST_RST;
                        cnt_d    = '0;
                        loss_inc = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_FAIL: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = ST_RST;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RST;
            cnt_q     <= '0;
            retries_q <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            pll_rst_q <= (state_d == ST_RST) || (state_d == ST_FAIL);
            ready_q   <= (state_d == ST_RUN);
            fail_q    <= (state_d == ST_FAIL);
        end
    end

    assign pll_rst = pll_rst_q;
    assign ready   = ready_q;
    assign fail    = fail_q;
    assign retries = retries_q;
    assign state   = state_q;

`ifdef PLL_SUPV_LOSS_COUNT_EN
    logic [7:0] loss_count_q;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            loss_count_q <= '0;
        end else if (loss_inc && (loss_count_q != 8'hFF)) begin
            loss_count_q <= loss_count_q + 8'd1;
        end
    end

    assign loss_count = loss_count_q;
`else
    logic unused_loss_inc;
    assign unused_loss_inc = loss_inc;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: vector table plus corner-case sequences.
module tb_pll_lock_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int LOSS_FILTER   = 3;
    localparam int MAX_RETRIES   = 2;

    localparam logic [2:0] S_RST  = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_STAB = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_FAIL = 3'd4;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst;
    logic       ready;
    logic       fail;
    logic [1:0] retries;
    logic [2:0] state;
`ifdef PLL_SUPV_LOSS_COUNT_EN
    logic [7:0] loss_count;
`endif

    always #5 refclk = ~refclk;

    pll_lock_supervisor #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .LOSS_FILTER   (LOSS_FILTER),
        .MAX_RETRIES   (MAX_RETRIES)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .ready      (ready),
        .fail       (fail),
        .retries    (retries),
        .state      (state)
`ifdef PLL_SUPV_LOSS_COUNT_EN
        ,
        .loss_count (loss_count)
`endif
    );

    typedef struct {
        string      name;
        logic [2:0] st;
        logic       prst;
        logic       rdy;
        logic       fl;
        logic [1:0] rt;
    } exp_t;

    typedef struct {
        logic       r;
        logic       lk;
        logic       rs;
        int         n;
        string      name;
        logic [2:0] st;
        logic       prst;
        logic       rdy;
        logic       fl;
        logic [1:0] rt;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    // Expectation is queued as stimulus is applied, then popped once the DUT has advanced.
    task automatic check(input string name, input int n, input logic [2:0] st, input logic prst,
                         input logic rdy, input logic fl, input logic [1:0] rt);
        exp_t e;
        e.name = name; e.st = st; e.prst = prst; e.rdy = rdy; e.fl = fl; e.rt = rt;
        sb_q.push_back(e);
        if (n > 0) step(n);
        else #1;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            if ({state, pll_rst, ready, fail, retries} !== {e.st, e.prst, e.rdy, e.fl, e.rt}) begin
                n_fail++;
                $display("FAIL %s: got state=%0d pll_rst=%b ready=%b fail=%b retries=%0d, expected state=%0d pll_rst=%b ready=%b fail=%b retries=%0d",
                         e.name, state, pll_rst, ready, fail, retries, e.st, e.prst, e.rdy, e.fl, e.rt);
            end else begin
                $display("[TB] ok %s: state=%0d pll_rst=%b ready=%b fail=%b retries=%0d",
                         e.name, state, pll_rst, ready, fail, retries);
            end
        end
    endtask

`ifdef PLL_SUPV_LOSS_COUNT_EN
    task automatic chk_loss(input string name, input logic [7:0] exp_cnt);
        n_tests++;
        if (loss_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s: loss_count got %0d expected %0d", name, loss_count, exp_cnt);
        end else begin
            $display("[TB] ok %s: loss_count=%0d", name, loss_count);
        end
    endtask
`endif

    task automatic add(input logic r, input logic lk, input logic rs, input int n, input string name,
                       input logic [2:0] st, input logic prst, input logic rdy, input logic fl,
                       input logic [1:0] rt);
        vec_t v;
        v.r = r; v.lk = lk; v.rs = rs; v.n = n; v.name = name;
        v.st = st; v.prst = prst; v.rdy = rdy; v.fl = fl; v.rt = rt;
        vecs.push_back(v);
    endtask

    initial begin
        // Normal bring-up
        add(1, 0, 0, 2,  "reset_values",   S_RST,  1, 0, 0, 0);
        add(0, 0, 0, 3,  "t1_rst_hold",    S_RST,  1, 0, 0, 0);
        add(0, 0, 0, 1,  "t1_wait",        S_WAIT, 0, 0, 0, 0);
        add(0, 1, 0, 2,  "t1_sync_lat",    S_WAIT, 0, 0, 0, 0);
        add(0, 1, 0, 1,  "t1_stab",        S_STAB, 0, 0, 0, 0);
        add(0, 1, 0, 7,  "t1_stab_hold",   S_STAB, 0, 0, 0, 0);
        add(0, 1, 0, 1,  "t1_run",         S_RUN,  0, 1, 0, 0);
        // Timeout retries into FAIL, then restart
        add(1, 0, 0, 2,  "t2_reset",       S_RST,  1, 0, 0, 0);
        add(0, 0, 0, 4,  "t2_wait0",       S_WAIT, 0, 0, 0, 0);
        add(0, 0, 0, 19, "t2_wait0_last",  S_WAIT, 0, 0, 0, 0);
        add(0, 0, 0, 1,  "t2_retry1",      S_RST,  1, 0, 0, 1);
        add(0, 0, 0, 3,  "t2_rst1_hold",   S_RST,  1, 0, 0, 1);
        add(0, 0, 0, 1,  "t2_wait1",       S_WAIT, 0, 0, 0, 1);
        add(0, 0, 0, 19, "t2_wait1_last",  S_WAIT, 0, 0, 0, 1);
        add(0, 0, 0, 1,  "t2_retry2",      S_RST,  1, 0, 0, 2);
        add(0, 0, 0, 4,  "t2_wait2",       S_WAIT, 0, 0, 0, 2);
        add(0, 0, 0, 19, "t2_wait2_last",  S_WAIT, 0, 0, 0, 2);
        add(0, 0, 0, 1,  "t2_fail",        S_FAIL, 1, 0, 1, 2);
        add(0, 0, 0, 5,  "t2_fail_hold",   S_FAIL, 1, 0, 1, 2);
        add(0, 0, 1, 1,  "t2_restart",     S_RST,  1, 0, 0, 0);
        add(0, 0, 0, 3,  "t2_rst_after",   S_RST,  1, 0, 0, 0);
        add(0, 0, 0, 1,  "t2_wait_after",  S_WAIT, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst        = vecs[i].r;
            pll_locked = vecs[i].lk;
            restart    = vecs[i].rs;
            check(vecs[i].name, vecs[i].n, vecs[i].st, vecs[i].prst, vecs[i].rdy,
                  vecs[i].fl, vecs[i].rt);
        end
        restart = 1'b0;

        // Stability glitch during STAB
        rst = 1'b1; pll_locked = 1'b1;
        check("t3_reset", 2, S_RST, 1, 0, 0, 0);
        rst = 1'b0;
        check("t3_wait", 4, S_WAIT, 0, 0, 0, 0);
        check("t3_stab", 1, S_STAB, 0, 0, 0, 0);
        check("t3_stab_cnt5", 5, S_STAB, 0, 0, 0, 0);
        pll_locked = 1'b0;
        check("t3_glitch_in", 1, S_STAB, 0, 0, 0, 0);
        pll_locked = 1'b1;
        check("t3_glitch_sync", 1, S_STAB, 0, 0, 0, 0);
        check("t3_back_wait", 1, S_WAIT, 0, 0, 0, 0);
        check("t3_restab", 1, S_STAB, 0, 0, 0, 0);
        check("t3_restab_hold", 7, S_STAB, 0, 0, 0, 0);
        check("t3_run", 1, S_RUN, 0, 1, 0, 0);

        // Loss filter in RUN
`ifdef PLL_SUPV_LOSS_COUNT_EN
        chk_loss("t4_loss_init", 8'd0);
`endif
        pll_locked = 1'b0;
        check("t4_low1", 1, S_RUN, 0, 1, 0, 0);
        check("t4_low2", 1, S_RUN, 0, 1, 0, 0);
        pll_locked = 1'b1;
        check("t4_filt_a", 1, S_RUN, 0, 1, 0, 0);
        check("t4_filt_b", 2, S_RUN, 0, 1, 0, 0);
        check("t4_filt_c", 1, S_RUN, 0, 1, 0, 0);
        pll_locked = 1'b0;
        check("t4_loss_sync", 2, S_RUN, 0, 1, 0, 0);
        check("t4_loss_two", 2, S_RUN, 0, 1, 0, 0);
        check("t4_loss_rst", 1, S_RST, 1, 0, 0, 0);
`ifdef PLL_SUPV_LOSS_COUNT_EN
        chk_loss("t4_loss_one", 8'd1);
        restart = 1'b1;
        check("t4_restart", 1, S_RST, 1, 0, 0, 0);
        restart = 1'b0;
        chk_loss("t4_loss_kept", 8'd1);
`endif

        // restart versus timeout, held restart, async reset from RUN
        rst = 1'b1; pll_locked = 1'b0;
        check("t5_reset", 2, S_RST, 1, 0, 0, 0);
        rst = 1'b0;
        check("t5_wait", 4, S_WAIT, 0, 0, 0, 0);
        check("t5_wait_last", 19, S_WAIT, 0, 0, 0, 0);
        restart = 1'b1;
        check("t5_restart_vs_timeout", 1, S_RST, 1, 0, 0, 0);
        check("t5_restart_held", 4, S_RST, 1, 0, 0, 0);
        restart = 1'b0;
        check("t5_rst_cnt0", 3, S_RST, 1, 0, 0, 0);
        check("t5_wait_again", 1, S_WAIT, 0, 0, 0, 0);
        pll_locked = 1'b1;
        check("t5_stab", 3, S_STAB, 0, 0, 0, 0);
        check("t5_run", 8, S_RUN, 0, 1, 0, 0);
        #2;
        rst = 1'b1;
        check("t5_async_rst", 0, S_RST, 1, 0, 0, 0);
`ifdef PLL_SUPV_LOSS_COUNT_EN
        chk_loss("t5_loss_cleared", 8'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
